// File: rtl/fb_pkg.sv
// Shared defaults, grant encoding and sizing helper for the frame-buffer port arbiter.
package fb_pkg;
    localparam int FB_ADDR_W = 16;
    localparam int FB_DATA_W = 7;

    typedef enum logic [1:0] {
        GNT_NONE = 2'd0,
        GNT_RD   = 2'd1,
        GNT_WR   = 2'd2
    } gnt_e;

    // Occupancy needs one extra bit so a full FIFO is distinguishable from empty.
    function automatic int fb_level_w(input int depth);
        return $clog2(depth) + 1;
    endfunction
endpackage

// File: rtl/fb_port_arbiter_if.sv
// Scanout, pixel-write and RAM signals of the frame-buffer arbiter bundled as one interface.
interface fb_port_arbiter_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
);
    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic [DATA_W-1:0] rd_data;
    logic              rd_valid;
    logic              rd_miss;
    logic              wr_valid;
    logic              wr_ready;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_we;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    // Master is the surrounding system (requesters and RAM); slave is the arbiter.
    modport master (
        output rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        input  rd_data, rd_valid, rd_miss, wr_ready, mem_addr, mem_we, mem_wdata
    );

    modport slave (
        input  rd_req, rd_addr, wr_valid, wr_addr, wr_data, mem_rdata,
        output rd_data, rd_valid, rd_miss, wr_ready, mem_addr, mem_we, mem_wdata
    );
endinterface

// File: rtl/fb_wr_fifo.sv
// Parameterised synchronous FIFO for queued pixel writes; pointers wrap modulo DEPTH.
module fb_wr_fifo
    import fb_pkg::*;
#(
    parameter int  WIDTH   = FB_ADDR_W + FB_DATA_W,
    parameter int  DEPTH   = 4,
    localparam int PTR_W   = $clog2(DEPTH),
    localparam int LEVEL_W = fb_level_w(DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push,
    input  logic               pop,
    input  logic [WIDTH-1:0]   push_data,
    output logic [WIDTH-1:0]   head,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);
    logic [WIDTH-1:0] store [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (level == LEVEL_W'(DEPTH));
    assign empty   = (level == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = store[rd_ptr];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    // Storage needs no reset: discarding entries only requires clearing the pointers.
    always_ff @(posedge clk) begin
        if (do_push) store[wr_ptr] <= push_data;
    end
endmodule

// File: rtl/fb_port_arbiter.sv
// Frame-buffer port arbiter: scanout reads own the single RAM port, pixel writes
// queue in a FIFO and drain in read-free cycles or through a forced starvation slot.
module fb_port_arbiter
    import fb_pkg::*;
#(
    parameter int  ADDR_W       = FB_ADDR_W,
    parameter int  DATA_W       = FB_DATA_W,
    parameter int  FIFO_DEPTH   = 4,
    parameter int  STARVE_LIMIT = 3,
    localparam int LEVEL_W      = fb_level_w(FIFO_DEPTH)
) (
    input  logic               clk,
    input  logic               reset,
    fb_port_arbiter_if.slave   bus,
    output logic [LEVEL_W-1:0] fifo_level
);
    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    logic                     full;
    logic                     empty;
    logic                     pop;
    logic                     forced;
    logic [ADDR_W+DATA_W-1:0] head;
    logic [ADDR_W-1:0]        head_addr;
    logic [DATA_W-1:0]        head_data;
    logic [SC_W-1:0]          starve_cnt;
    logic                     rd_v1;
    logic                     rd_v2;
    gnt_e                     gnt;

    fb_wr_fifo #(.WIDTH(ADDR_W + DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .push      (bus.wr_valid),
        .pop       (pop),
        .push_data ({bus.wr_addr, bus.wr_data}),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .level     (fifo_level)
    );

    assign {head_addr, head_data} = head;
    assign bus.wr_ready = !full;
    assign pop = (gnt == GNT_WR);

    // Grant uses only registered state plus the live read request; the forced slot beats scanout.
    always_comb begin
        forced = (starve_cnt == SC_W'(STARVE_LIMIT)) && !empty;
        gnt    = GNT_NONE;
        if (forced)           gnt = GNT_WR;
        else if (bus.rd_req)  gnt = GNT_RD;
        else if (!empty)      gnt = GNT_WR;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bus.mem_addr  <= '0;
            bus.mem_we    <= 1'b0;
            bus.mem_wdata <= '0;
            bus.rd_data   <= '0;
            bus.rd_valid  <= 1'b0;
            bus.rd_miss   <= 1'b0;
            rd_v1         <= 1'b0;
            rd_v2         <= 1'b0;
            starve_cnt    <= '0;
        end else begin
            case (gnt)
                GNT_RD: begin
                    bus.mem_addr <= bus.rd_addr;
                    bus.mem_we   <= 1'b0;
                end
                GNT_WR: begin
                    bus.mem_addr  <= head_addr;
                    bus.mem_wdata <= head_data;
                    bus.mem_we    <= 1'b1;
                end
                default: bus.mem_we <= 1'b0;
            endcase

            // Address register, RAM access and output register give three cycles of read latency.
            rd_v1        <= (gnt == GNT_RD);
            rd_v2        <= rd_v1;
            bus.rd_valid <= rd_v2;
            if (rd_v2) bus.rd_data <= bus.mem_rdata;
            bus.rd_miss  <= forced && bus.rd_req;

            if (gnt == GNT_WR)
                starve_cnt <= '0;
            else if (full && bus.rd_req && (starve_cnt != SC_W'(STARVE_LIMIT)))
                starve_cnt <= starve_cnt + 1'b1;
        end
    end
endmodule

// File: tb/tb_fb_port_arbiter.sv
// Scoreboard bench for fb_port_arbiter: stimulus queues expected reads, writes and misses; a monitor checks them.
`timescale 1ns/1ps
module tb_fb_port_arbiter;
    import fb_pkg::*;

    localparam int ADDR_W       = FB_ADDR_W;
    localparam int DATA_W       = FB_DATA_W;
    localparam int FIFO_DEPTH   = 4;
    localparam int STARVE_LIMIT = 3;
    localparam int LEVEL_W      = $clog2(FIFO_DEPTH) + 1;

    typedef struct {
        logic [DATA_W-1:0] data;
        int                cyc;
    } rd_exp_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wr_exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic [LEVEL_W-1:0] fifo_level;
    int                 errors = 0;
    int                 checks = 0;
    int                 cyc = 0;
    int                 wi = 0;

    rd_exp_t           exp_rd[$];
    wr_exp_t           exp_wr[$];
    int                exp_miss[$];
    logic [DATA_W-1:0] ram [0:65535];

    fb_port_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

    fb_port_arbiter #(
        .ADDR_W       (ADDR_W),
        .DATA_W       (DATA_W),
        .FIFO_DEPTH   (FIFO_DEPTH),
        .STARVE_LIMIT (STARVE_LIMIT)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .bus        (bus),
        .fifo_level (fifo_level)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Preloaded RAM contents: (addr*5+3) mod 128.
    function automatic logic [DATA_W-1:0] pre(input logic [ADDR_W-1:0] a);
        return DATA_W'(int'(a) * 5 + 3);
    endfunction

    initial begin
        for (int i = 0; i < 65536; i++) ram[i] <= pre(ADDR_W'(i));
    end

    // Single-port synchronous RAM: read data appears one cycle after the address.
    always @(posedge clk) begin
        if (bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
        bus.mem_rdata <= ram[bus.mem_addr];
    end

    task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    // Monitor: every DUT output event is matched against the head of its queue.
    always @(negedge clk) begin : monitor
        rd_exp_t re;
        wr_exp_t we;
        if (!reset) begin
            if (bus.rd_valid) begin
                if (exp_rd.size() == 0) check_output("rd_valid_unexpected", 32'(bus.rd_valid), 0);
                else begin
                    re = exp_rd.pop_front();
                    check_output("rd_data", 32'(bus.rd_data), 32'(re.data));
                    check_output("rd_latency_cycle", cyc, re.cyc);
                end
            end
            if (bus.mem_we) begin
                if (exp_wr.size() == 0) check_output("mem_we_unexpected", 32'(bus.mem_we), 0);
                else begin
                    we = exp_wr.pop_front();
                    check_output("mem_addr", 32'(bus.mem_addr), 32'(we.addr));
                    check_output("mem_wdata", 32'(bus.mem_wdata), 32'(we.data));
                end
            end
            if (bus.rd_miss) begin
                if (exp_miss.size() == 0) check_output("rd_miss_unexpected", 32'(bus.rd_miss), 0);
                else check_output("rd_miss_cycle", cyc, exp_miss.pop_front());
            end
        end
    end

    task automatic apply_stimulus(input logic rd, input logic [ADDR_W-1:0] raddr, input logic rd_exp,
                                  input logic [DATA_W-1:0] rdata_exp, input logic wv,
                                  input logic [ADDR_W-1:0] waddr, input logic [DATA_W-1:0] wdata,
                                  input logic wr_exp, output logic acc);
        bus.rd_req   = rd;
        bus.rd_addr  = raddr;
        bus.wr_valid = wv;
        bus.wr_addr  = waddr;
        bus.wr_data  = wdata;
        acc = wv && bus.wr_ready;
        if (rd && rd_exp) exp_rd.push_back('{rdata_exp, cyc + 3});
        if (acc && wr_exp) exp_wr.push_back('{waddr, wdata});
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        logic acc;
        for (int i = 0; i < n; i++) apply_stimulus(0, '0, 0, '0, 0, '0, '0, 0, acc);
    endtask

    task automatic wait_idle(input int budget);
        int n;
        n = 0;
        while ((exp_rd.size() != 0 || exp_wr.size() != 0 || exp_miss.size() != 0 || fifo_level != 0) && n < budget) begin
            idle(1);
            n++;
        end
        if (exp_rd.size() != 0 || exp_wr.size() != 0 || exp_miss.size() != 0 || fifo_level != 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL drain_timeout: rd=%0d wr=%0d miss=%0d level=%0d still pending after %0d cycles",
                     exp_rd.size(), exp_wr.size(), exp_miss.size(), fifo_level, budget);
        end
        idle(3);
    endtask

    initial begin : watchdog
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin : stimulus
        logic acc;
        bus.rd_req   = 1'b0;
        bus.rd_addr  = '0;
        bus.wr_valid = 1'b0;
        bus.wr_addr  = '0;
        bus.wr_data  = '0;

        @(posedge clk);
        #1;
        check_output("reset_rd_valid", 32'(bus.rd_valid), 0);
        check_output("reset_rd_miss", 32'(bus.rd_miss), 0);
        check_output("reset_rd_data", 32'(bus.rd_data), 0);
        check_output("reset_mem_we", 32'(bus.mem_we), 0);
        check_output("reset_mem_addr", 32'(bus.mem_addr), 0);
        check_output("reset_mem_wdata", 32'(bus.mem_wdata), 0);
        check_output("reset_wr_ready", 32'(bus.wr_ready), 1);
        check_output("reset_fifo_level", 32'(fifo_level), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(2);

        $display("[TB] reads only");
        for (int c = 0; c < 160; c++)
            apply_stimulus(1, ADDR_W'(c), 1, pre(ADDR_W'(c)), 0, '0, '0, 0, acc);
        wait_idle(20);

        $display("[TB] writes only");
        for (int i = 0; i < 8; i++) begin
            check_output("t2_wr_ready", 32'(bus.wr_ready), 1);
            apply_stimulus(0, '0, 0, '0, 1, ADDR_W'(100 + i), DATA_W'(i), 1, acc);
            check_output("t2_level", 32'(fifo_level), 1);
        end
        wait_idle(20);

        $display("[TB] fill and forced write");
        for (int c = 0; c < 10; c++) begin
            if (c == 4 || c == 7) begin
                check_output("t3_full_level", 32'(fifo_level), 4);
                check_output("t3_full_wr_ready", 32'(bus.wr_ready), 0);
            end
            if (c == 8) begin
                check_output("t3_after_force_level", 32'(fifo_level), 3);
                check_output("t3_after_force_wr_ready", 32'(bus.wr_ready), 1);
            end
            if (c == 7) exp_miss.push_back(cyc + 1);
            apply_stimulus(1, ADDR_W'(10 + c), (c != 7), pre(ADDR_W'(10 + c)),
                           (c < 4), ADDR_W'(300 + c), DATA_W'(16 + c), 1, acc);
            if (c < 4) check_output("t3_push_accepted", 32'(acc), 1);
        end
        wait_idle(30);

        $display("[TB] interleave");
        wi = 0;
        for (int c = 0; c < 16; c++) begin
            apply_stimulus((c % 2) == 0, ADDR_W'(20 + c), 1, pre(ADDR_W'(20 + c)),
                           (wi < 8), ADDR_W'(200 + wi), DATA_W'(64 + wi), 1, acc);
            if (acc) wi++;
        end
        check_output("t4_writes_accepted", wi, 8);
        wait_idle(30);
        for (int i = 0; i < 8; i++)
            apply_stimulus(1, ADDR_W'(200 + i), 1, DATA_W'(64 + i), 0, '0, '0, 0, acc);
        wait_idle(20);

        $display("[TB] coherency");
        apply_stimulus(0, '0, 0, '0, 1, ADDR_W'(7), 7'h55, 1, acc);
        check_output("t5_queued_level", 32'(fifo_level), 1);
        apply_stimulus(1, ADDR_W'(7), 1, pre(ADDR_W'(7)), 0, '0, '0, 0, acc);
        check_output("t5_read_priority_level", 32'(fifo_level), 1);
        wait_idle(20);
        apply_stimulus(1, ADDR_W'(7), 1, 7'h55, 0, '0, '0, 0, acc);
        wait_idle(20);

        $display("[TB] reset mid-operation");
        apply_stimulus(0, '0, 0, '0, 1, ADDR_W'(400), 7'h11, 1, acc);
        apply_stimulus(0, '0, 0, '0, 1, ADDR_W'(401), 7'h12, 0, acc);
        apply_stimulus(1, ADDR_W'(30), 0, '0, 1, ADDR_W'(402), 7'h13, 0, acc);
        apply_stimulus(1, ADDR_W'(31), 0, '0, 1, ADDR_W'(403), 7'h14, 0, acc);
        check_output("t6_level_before_reset", 32'(fifo_level), 3);
        bus.rd_req   = 1'b0;
        bus.wr_valid = 1'b0;
        reset = 1'b1;
        #1;
        check_output("t6_level_in_reset", 32'(fifo_level), 0);
        check_output("t6_wr_ready_in_reset", 32'(bus.wr_ready), 1);
        check_output("t6_rd_valid_in_reset", 32'(bus.rd_valid), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(6);

        apply_stimulus(0, '0, 0, '0, 1, ADDR_W'(410), 7'h21, 0, acc);
        idle(1);
        check_output("t6_mem_we_before_reset", 32'(bus.mem_we), 1);
        reset = 1'b1;
        #1;
        check_output("t6_mem_we_async_clear", 32'(bus.mem_we), 0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        idle(4);

        check_output("sb_rd_left", exp_rd.size(), 0);
        check_output("sb_wr_left", exp_wr.size(), 0);
        check_output("sb_miss_left", exp_miss.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
